// File: rtl/serial_sub_ctrl_if.sv
// Handshake and data bundle between a requester and the bit-serial subtractor.
//
// Handshake: the requester raises start for one or more cycles with a, b and
// bin stable; the block accepts it only on a rising edge where it is idle. After
// acceptance the block ignores start and the operand lines until it has raised
// done for exactly one cycle and returned to idle. busy marks the computation
// cycles. diff and borrow_out are valid from the done cycle until the next
// accepted start.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    // Requester side
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow_out
    );

    // Subtractor side
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one shared full-subtractor cell walks a WIDTH-bit
// operand pair LSB first, one bit per clock, with the borrow held in a register.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_sub_ctrl_if.slave    bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             load;
    logic             last;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             brw;
    logic             bout_r;
    logic [CW-1:0]    cnt;

    logic             cell_x;
    logic             cell_y;
    logic             cell_c;
    logic             cell_d;
    logic             cell_bo;

    // Full-subtractor cell on the current LSBs and the running borrow
    assign cell_x  = a_sr[0];
    assign cell_y  = b_sr[0];
    assign cell_c  = brw;
    assign cell_d  = cell_x ^ cell_y ^ cell_c;
    assign cell_bo = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & cell_c);

    // Next state, start acceptance and last-bit detection
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand capture on accept, then one bit per clock while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            bout_r <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            brw    <= bus.bin;
            res_sr <= '0;
            bout_r <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= {cell_d, res_sr[WIDTH-1:1]};
            brw    <= cell_bo;
            if (last) begin
                // Counter parks at WIDTH-1 until the next accepted start
                bout_r <= cell_bo;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.diff       = res_sr;
    assign bus.borrow_out = bout_r;
    assign dbg_state      = state;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: directed cases on an 8-bit instance, then a
// random sweep on the 8-bit and a 2-bit instance against an arithmetic model.
module tb_serial_sub_ctrl;
    logic clk;
    logic rst_n;
    logic [1:0] dbg8;
    logic [1:0] dbg2;

    int n_cmp;
    int n_err;
    logic [32:0] exp_q[$];

    serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
    serial_sub_ctrl_if #(.WIDTH(2)) if2 ();

    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8), .dbg_state(dbg8));
    serial_sub_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .dbg_state(dbg2));

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: plain unsigned arithmetic, {borrow, diff}
    function automatic logic [32:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic bin);
        logic [33:0] full;
        logic [31:0] mask;
        logic        brw;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {2'b00, a} - {2'b00, b} - {33'd0, bin};
        brw  = ({2'b00, a} < ({2'b00, b} + {33'd0, bin}));
        return {brw, full[31:0] & mask};
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? if8.busy : if2.busy;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? if8.done : if2.done;
    endfunction

    function automatic logic [31:0] get_diff(input int w);
        return (w == 8) ? {24'd0, if8.diff} : {30'd0, if2.diff};
    endfunction

    function automatic logic get_bout(input int w);
        return (w == 8) ? if8.borrow_out : if2.borrow_out;
    endfunction

    // drive a request at the current negedge and record its expected result
    task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin);
        if (w == 8) begin
            if8.start = 1'b1; if8.a = a[7:0]; if8.b = b[7:0]; if8.bin = bin;
        end else begin
            if2.start = 1'b1; if2.a = a[1:0]; if2.b = b[1:0]; if2.bin = bin;
        end
        exp_q.push_back(model(w, a, b, bin));
    endtask

    // drop start and scramble operands to show they are not re-sampled
    task automatic drop_start(input int w);
        if (w == 8) begin
            if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
        end else begin
            if2.start = 1'b0; if2.a = 2'($urandom); if2.b = 2'($urandom); if2.bin = 1'($urandom);
        end
    endtask

    // follow an accepted request through RUN and DONE, then one IDLE cycle
    task automatic wait_done(input int w, input string tag);
        int          lat;
        logic [32:0] e;
        logic [31:0] held;
        lat = -1;
        for (int n = 0; n < w + 4; n++) begin
            @(negedge clk);
            if (n == 0) drop_start(w);
            if (get_done(w)) begin
                lat = n;
                break;
            end
            check({tag, " busy"}, {31'd0, get_busy(w)}, 32'd1);
        end
        check({tag, " latency"}, lat, w);
        check({tag, " busy_in_done"}, {31'd0, get_busy(w)}, 32'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
        check({tag, " diff"}, get_diff(w), e[31:0]);
        check({tag, " borrow"}, {31'd0, get_bout(w)}, {31'd0, e[32]});
        held = get_diff(w);
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'd0, get_done(w)}, 32'd0);
        check({tag, " idle_busy"}, {31'd0, get_busy(w)}, 32'd0);
        check({tag, " diff_held"}, get_diff(w), held);
        check({tag, " borrow_held"}, {31'd0, get_bout(w)}, {31'd0, e[32]});
    endtask

    initial begin
        int done_cnt;
        int seen_done;
        n_cmp = 0;
        n_err = 0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.bin = 1'b0;

        // reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", {31'd0, if8.busy}, 32'd0);
        check("rst done", {31'd0, if8.done}, 32'd0);
        check("rst diff", {24'd0, if8.diff}, 32'd0);
        check("rst borrow", {31'd0, if8.borrow_out}, 32'd0);
        check("rst state", {30'd0, dbg8}, 32'd0);
        rst_n = 1'b1;

        // directed cases
        issue(8, 32'h5A, 32'h3C, 1'b0); wait_done(8, "basic");
        issue(8, 32'h3C, 32'h5A, 1'b0); wait_done(8, "underflow");
        issue(8, 32'h00, 32'h00, 1'b1); wait_done(8, "bin_chain");
        issue(8, 32'hFF, 32'h00, 1'b0); wait_done(8, "all_ones");

        // start while busy and in DONE is ignored
        issue(8, 32'h5A, 32'h3C, 1'b0);
        done_cnt = 0;
        for (int n = 0; n <= 9; n++) begin
            @(negedge clk);
            if (get_done(8)) done_cnt++;
            if (n == 8) begin
                check("busy_start diff", {24'd0, if8.diff}, 32'h1E);
                check("busy_start borrow", {31'd0, if8.borrow_out}, 32'd0);
            end
            if (n == 0 || n == 3) begin
                if8.start = 1'b0;
            end
            if (n == 2 || n == 7) begin
                if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01; if8.bin = 1'b0;
            end
        end
        check("busy_start done_pulses", done_cnt, 1);
        check("busy_start idle", {31'd0, if8.busy}, 32'd0);
        void'(exp_q.pop_front());
        // start still high in IDLE: accepted on the next edge
        exp_q.push_back(model(8, 32'h01, 32'h01, 1'b0));
        wait_done(8, "after_busy");

        // asynchronous reset in the middle of a run
        issue(8, 32'h5A, 32'h3C, 1'b0);
        for (int n = 0; n <= 4; n++) begin
            @(negedge clk);
            if (n == 0) drop_start(8);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", {31'd0, if8.busy}, 32'd0);
        check("midrst done", {31'd0, if8.done}, 32'd0);
        check("midrst diff", {24'd0, if8.diff}, 32'd0);
        check("midrst borrow", {31'd0, if8.borrow_out}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (if8.done || if8.busy) seen_done++;
        end
        check("midrst no_activity", seen_done, 0);
        issue(8, 32'h80, 32'h01, 1'b0); wait_done(8, "post_rst");

        // random sweep on both widths
        for (int i = 0; i < 500; i++) begin
            issue(8, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            wait_done(8, "rnd8");
        end
        for (int i = 0; i < 500; i++) begin
            issue(2, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            wait_done(2, "rnd2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
